vec_acc_engine: RTL and testbench
=================================

# vec_acc_engine

Memory-mapped vector accelerator that sits directly downstream of the data RAM's accelerator ports. It consumes the 256-word operand windows A and B mirrored out of RAM and computes a selectable element-wise operation, LANES_PER_CYCLE lanes per cycle. It drives the 256-word result window that the RAM writes back into its result region every cycle. Control is a start/busy/done handshake from a core-side register interface.

## Interface
- NUM_LANES, 256, number of 32-bit elements per operand window; must equal result window size
- LANES_PER_CYCLE, 8, lanes computed per RUN cycle; power of two dividing NUM_LANES
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start_i  in  1  request a run; sampled only in IDLE
- op_i  in  2  operation select, latched on start acceptance
- busy_o  out  1  high in RUN
- done_o  out  1  one-cycle pulse in DONE
- sum_o  out  32  wrapping sum of all lane results of the last run
- acc_in_A  in  [3:0][7:0] x NUM_LANES  operand A window
- acc_in_B  in  [3:0][7:0] x NUM_LANES  operand B window
- acc_out  out  [3:0][7:0] x NUM_LANES  registered result window

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when start_i=1.
  - Latches op_i.
  - Clears chunk counter and sum_o.
- RUN processes one chunk per cycle.
  - Chunk c covers lanes c*LANES_PER_CYCLE .. c*LANES_PER_CYCLE+LANES_PER_CYCLE-1.
  - Each lane result is registered into acc_out.
  - The chunk's results are added into sum_o, mod 2^32.
  - After chunk NUM_LANES/LANES_PER_CYCLE-1 the counter wraps to 0 and the FSM enters DONE.
- DONE lasts one cycle, then returns to IDLE.
- start_i is ignored in RUN and DONE. No queuing.
- Ops, per 32-bit lane, unsigned:
  - 00: A+B, mod 2^32.
  - 01: A-B, mod 2^32.
  - 10: byte-wise saturating add. Each byte is min(A[k]+B[k], 255).
  - 11: low 32 bits of A*B (see Configuration).
- Operands are read live from acc_in_A/B in the cycle a chunk is processed. Software must not write the A/B regions while busy_o=1.
- acc_out lanes not yet overwritten hold previous-run values. acc_out is never combinationally driven.
- Reset at any time, including mid-run:
  - FSM to IDLE, counter to 0.
  - busy_o=0, done_o=0, sum_o=0.
  - All acc_out lanes 0.
  - The latched op resets to 00.

## Timing
- Cycle 0: start_i=1 in IDLE.
- Cycles 1..NUM_LANES/LANES_PER_CYCLE (32 at defaults): RUN, busy_o=1.
- acc_out for chunk c updates at the end of RUN cycle c+1.
- Cycle 33 at defaults: DONE. done_o=1, busy_o=0, sum_o final and stable until the next accepted start.
- RAM result region reflects the final acc_out one cycle after DONE.
- Earliest next start is cycle 34 (IDLE).
- Run-to-run period at defaults: 34 cycles.

## Configuration
- VEC_ACC_MUL_EN defined: op 11 computes the low 32 bits of A*B, using LANES_PER_CYCLE 32x32 multipliers.
- VEC_ACC_MUL_EN undefined:
  - No multipliers are instantiated.
  - op 11 produces result 0 in every lane and contributes 0 to sum_o.
  - The FSM and timing are unchanged.

## Structure
- Package vec_acc_pkg holds:
  - op_e: ADD, SUB, SATB, MUL.
  - state_e: IDLE, RUN, DONE.
  - Default constants for NUM_LANES and LANES_PER_CYCLE.
  - The lane word typedef [3:0][7:0].
- Sub-module vec_acc_lane:
  - Combinational single-lane ALU: A, B, op -> 32-bit result.
  - Instantiated LANES_PER_CYCLE times.
  - Contains the VEC_ACC_MUL_EN guard.
- Top holds the FSM, chunk counter, lane mux/demux, acc_out registers and the sum_o adder tree.

## Test plan
- Reset mid-run, asserting rst at RUN cycle 10 -> busy_o=0, acc_out all 0, sum_o=0. A new start then completes normally in 34 cycles.
- ADD, A[i]=i, B[i]=1 -> acc_out[i]=i+1; sum_o=32896; done_o pulses exactly at cycle 33.
- SUB, A[i]=0, B[i]=1 -> every lane 0xFFFFFFFF; sum_o=0xFFFFFF00 (wrap).
- SATB, A=0xF0F00010, B=0x20010010 in all lanes -> lanes 0xFFF10020.
- MUL, A=0x00010000, B=0x00010003 -> lanes 0x00030000 with VEC_ACC_MUL_EN; 0 without.
- start_i held high continuously -> runs accepted only at cycles 0, 34, 68; done_o never overlaps busy_o.

Source files
------------

// File: rtl/vec_acc_pkg.sv
// Shared types and defaults for the vec_acc_engine vector accelerator.
package vec_acc_pkg;

   localparam int unsigned NUM_LANES_DEF       = 256;
   localparam int unsigned LANES_PER_CYCLE_DEF = 8;

   typedef logic [3:0][7:0] word_t;

   typedef enum logic [1:0] {
      ADD  = 2'b00,
      SUB  = 2'b01,
      SATB = 2'b10,
      MUL  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   function automatic logic [7:0] sat_add8(input logic [7:0] x, input logic [7:0] y);
      logic [8:0] s;
      s = {1'b0, x} + {1'b0, y};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

endpackage

// File: rtl/vec_acc_lane.sv
// Combinational single-lane ALU for vec_acc_engine.
// Multiplier present only when VEC_ACC_MUL_EN is defined; otherwise op MUL yields 0.
module vec_acc_lane
   import vec_acc_pkg::*;
(
   input  word_t       a,
   input  word_t       b,
   input  op_e         op,
   output logic [31:0] result
);

   always_comb begin
      result = '0;
      case (op)
         ADD:  result = a + b;
         SUB:  result = a - b;
         SATB: begin
            for (int unsigned k = 0; k < 4; k++) begin
               result[8*k +: 8] = sat_add8(a[k], b[k]);
            end
         end
         MUL: begin
`ifdef VEC_ACC_MUL_EN
            result = a * b;
`else
            result = '0;
`endif
         end
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/vec_acc_engine.sv
// Vector accelerator top: FSM, chunk sequencing, registered result window and running sum.
// Optional multiplier support is selected by the VEC_ACC_MUL_EN macro (see vec_acc_lane).
module vec_acc_engine
   import vec_acc_pkg::*;
#(
   parameter int unsigned NUM_LANES       = NUM_LANES_DEF,
   parameter int unsigned LANES_PER_CYCLE = LANES_PER_CYCLE_DEF
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start_i,
   input  logic [1:0]                    op_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic [31:0]                   sum_o,
   input  logic [NUM_LANES-1:0][3:0][7:0] acc_in_A,
   input  logic [NUM_LANES-1:0][3:0][7:0] acc_in_B,
   output logic [NUM_LANES-1:0][3:0][7:0] acc_out
);

   localparam int unsigned NUM_CHUNKS = NUM_LANES / LANES_PER_CYCLE;
   localparam int unsigned CW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam int unsigned IW         = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int unsigned LB         = $clog2(LANES_PER_CYCLE);
   localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   chunk_q;
   op_e             op_q;
   logic [31:0]     sum_q;
   logic [IW-1:0]   base;
   logic [31:0]     res [LANES_PER_CYCLE];
   logic [31:0]     chunk_sum;

   wire accept = (state_q == IDLE) && start_i;

   // Lane block size is a power of two, so the chunk base is a plain shift.
   assign base  = IW'(chunk_q) << LB;
   assign sum_o = sum_q;

   for (genvar l = 0; l < LANES_PER_CYCLE; l++) begin : g_lane
      vec_acc_lane u_lane (
         .a      (acc_in_A[base + IW'(l)]),
         .b      (acc_in_B[base + IW'(l)]),
         .op     (op_q),
         .result (res[l])
      );
   end

   always_comb begin
      chunk_sum = '0;
      for (int unsigned l = 0; l < LANES_PER_CYCLE; l++) begin
         chunk_sum = chunk_sum + res[l];
      end
   end

   always_comb begin
      state_d = state_q;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         IDLE: if (start_i) state_d = RUN;
         RUN: begin
            busy_o = 1'b1;
            if (chunk_q == LAST_CHUNK) state_d = DONE;
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         chunk_q <= '0;
         op_q    <= ADD;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q    <= op_e'(op_i);
            chunk_q <= '0;
            sum_q   <= '0;
         end else if (state_q == RUN) begin
            chunk_q <= (chunk_q == LAST_CHUNK) ? '0 : chunk_q + 1'b1;
            sum_q   <= sum_q + chunk_sum;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_out <= '0;
      end else if (state_q == RUN) begin
         for (int unsigned l = 0; l < LANES_PER_CYCLE; l++) begin
            acc_out[base + IW'(l)] <= res[l];
         end
      end
   end

endmodule

// File: tb/tb_vec_acc_engine.sv
// Self-checking bench for vec_acc_engine against a lane-array reference model.
module tb_vec_acc_engine;
   import vec_acc_pkg::*;

   localparam int unsigned NL  = NUM_LANES_DEF;
   localparam int unsigned LPC = LANES_PER_CYCLE_DEF;
   localparam int unsigned NC  = NL / LPC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic [1:0]  op_i = 2'b00;
   logic        busy_o, done_o;
   logic [31:0] sum_o;
   logic [NL-1:0][3:0][7:0] acc_in_A, acc_in_B, acc_out;

   logic [31:0] exp_out  [NL];
   logic [31:0] prev_out [NL];
   int checks = 0;
   int errors = 0;

   vec_acc_engine #(.NUM_LANES(NL), .LANES_PER_CYCLE(LPC)) dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .op_i     (op_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .sum_o    (sum_o),
      .acc_in_A (acc_in_A),
      .acc_in_B (acc_in_B),
      .acc_out  (acc_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_window(input string tag);
      int bad;
      int first;
      bad   = 0;
      first = 0;
      for (int i = 0; i < NL; i++) begin
         if (acc_out[i] !== exp_out[i]) begin
            if (bad == 0) first = i;
            bad++;
         end
      end
      checks++;
      assert (bad == 0) else begin
         errors++;
         $error("FAIL %s bad_lanes=%0d first_lane=%0d observed=%h expected=%h",
                tag, bad, first, acc_out[first], exp_out[first]);
      end
   endtask

   function automatic logic [31:0] ref_op(input int op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      int s;
      r = 32'h0;
      case (op)
         0: r = a + b;
         1: r = a - b;
         2: for (int k = 0; k < 4; k++) begin
               s = int'(a[8*k +: 8]) + int'(b[8*k +: 8]);
               if (s > 255) s = 255;
               r[8*k +: 8] = 8'(s);
            end
`ifdef VEC_ACC_MUL_EN
         3: r = a * b;
`else
         3: r = 32'h0;
`endif
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   // Starts a run at the current cycle (cycle 0) and follows it to the first IDLE cycle.
   task automatic run_op(input int op, input bit keep_start, output logic [31:0] sum_seen);
      logic [31:0] exp_sum;
      int idx;
      exp_sum = 32'h0;
      for (int i = 0; i < NL; i++) begin
         prev_out[i] = exp_out[i];
         exp_out[i]  = ref_op(op, acc_in_A[i], acc_in_B[i]);
         exp_sum     = exp_sum + exp_out[i];
      end
      start_i = 1'b1;
      op_i    = 2'(op);
      for (int cyc = 1; cyc <= NC + 1; cyc++) begin
         step();
         if (!keep_start) start_i = 1'b0;
         op_i = ~(2'(op));
         if (cyc <= NC) begin
            chk("busy_in_run", 32'(busy_o), 32'd1);
            chk("done_in_run", 32'(done_o), 32'd0);
            idx = (cyc - 1) * LPC;
            chk("chunk_not_yet_written", acc_out[idx], prev_out[idx]);
         end
         if (cyc >= 2) begin
            idx = (cyc - 2) * LPC + LPC - 1;
            chk("chunk_written", acc_out[idx], exp_out[idx]);
         end
      end
      chk("done_pulse", 32'(done_o), 32'd1);
      chk("busy_in_done", 32'(busy_o), 32'd0);
      chk("sum_final", sum_o, exp_sum);
      chk_window("window_final");
      step();
      chk("done_after", 32'(done_o), 32'd0);
      chk("busy_after", 32'(busy_o), 32'd0);
      chk("sum_stable", sum_o, exp_sum);
      sum_seen = sum_o;
   endtask

   task automatic fill_random();
      for (int i = 0; i < NL; i++) begin
         acc_in_A[i] = $urandom();
         acc_in_B[i] = $urandom();
      end
   endtask

   initial begin
      logic [31:0] s;
      for (int i = 0; i < NL; i++) begin
         acc_in_A[i] = 32'h0;
         acc_in_B[i] = 32'h0;
         exp_out[i]  = 32'h0;
      end

      step();
      step();
      chk("reset_busy", 32'(busy_o), 32'd0);
      chk("reset_done", 32'(done_o), 32'd0);
      chk("reset_sum", sum_o, 32'd0);
      chk_window("reset_window");
      rst = 1'b0;
      step();

      for (int i = 0; i < NL; i++) begin
         acc_in_A[i] = 32'(i);
         acc_in_B[i] = 32'd1;
      end
      run_op(0, 1'b0, s);
      chk("add_sum_literal", s, 32'd32896);
      chk("add_lane255", acc_out[255], 32'd256);

      for (int i = 0; i < NL; i++) begin
         acc_in_A[i] = 32'h0;
         acc_in_B[i] = 32'd1;
      end
      run_op(1, 1'b0, s);
      chk("sub_sum_literal", s, 32'hFFFFFF00);
      chk("sub_lane5", acc_out[5], 32'hFFFFFFFF);

      for (int i = 0; i < NL; i++) begin
         acc_in_A[i] = 32'hF0F00010;
         acc_in_B[i] = 32'h20010010;
      end
      run_op(2, 1'b0, s);
      chk("satb_lane17", acc_out[17], 32'hFFF10020);

      for (int i = 0; i < NL; i++) begin
         acc_in_A[i] = 32'h00010000;
         acc_in_B[i] = 32'h00010003;
      end
      run_op(3, 1'b0, s);
`ifdef VEC_ACC_MUL_EN
      chk("mul_lane200", acc_out[200], 32'h00030000);
`else
      chk("mul_lane200", acc_out[200], 32'h00000000);
`endif

      for (int r = 0; r < 4; r++) begin
         fill_random();
         run_op(int'($urandom_range(3, 0)), 1'b0, s);
      end

      fill_random();
      start_i = 1'b1;
      op_i    = 2'($urandom_range(3, 0));
      step();
      start_i = 1'b0;
      for (int c = 2; c <= 10; c++) step();
      chk("mid_run_busy_before_reset", 32'(busy_o), 32'd1);
      rst = 1'b1;
      #1;
      for (int i = 0; i < NL; i++) exp_out[i] = 32'h0;
      chk("mid_reset_busy", 32'(busy_o), 32'd0);
      chk("mid_reset_done", 32'(done_o), 32'd0);
      chk("mid_reset_sum", sum_o, 32'd0);
      chk_window("mid_reset_window");
      step();
      rst = 1'b0;
      step();
      run_op(int'($urandom_range(3, 0)), 1'b0, s);

      fill_random();
      run_op(int'($urandom_range(3, 0)), 1'b1, s);
      fill_random();
      run_op(int'($urandom_range(3, 0)), 1'b1, s);
      fill_random();
      run_op(int'($urandom_range(3, 0)), 1'b0, s);
      step();
      chk("idle_after_held_start", 32'(busy_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
